rv_mc: RTL and testbench
========================

RV_MC -- requirements
Module: rv_mc

Interface
- REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the unified instruction/data memory.
- REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
- REQ-005 SHALL have no other ports; the block is self-contained, with program and data held in internal memory.
- REQ-006 SHALL expose hierarchically visible internal nets named exactly we_rf and we_mem (register-file and memory write enables), a memory instance named MEM, and a word array inside it named RAM[0:MEM_WORDS-1] that can be loaded by $readmemh.

Function
- REQ-007 SHALL implement RV32I as a multi-cycle machine with one shared memory and one shared ALU.
- REQ-008 SHALL support these instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, and ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- REQ-009 SHALL treat every other opcode (including FENCE/SYSTEM) as a NOP that returns to FETCH after DECODE; no trap is raised.
- REQ-010 SHALL read memory combinationally, write it synchronously, index it by address[log2(MEM_WORDS)+1:2], ignore bits [1:0], and wrap out-of-range addresses modulo the memory size.
- REQ-011 SHALL use the FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER.
- REQ-012 SHALL perform, in FETCH: IR<=MEM[PC], OLDPC<=PC, PC<=PC+4, then go to DECODE.
- REQ-013 SHALL perform, in DECODE: latch A<=rs1 and B<=rs2 (x0 reads 0), compute ALUOUT<=OLDPC+imm_B, and dispatch on opcode.
- REQ-014 SHALL sequence loads as MEMADR (ALUOUT<=A+imm_I) -> MEMREAD (DATA<=MEM[ALUOUT]) -> MEMWB (rd<=DATA, we_rf=1) -> FETCH.
- REQ-015 SHALL sequence stores as MEMADR (address A+imm_S) -> MEMWRITE (MEM[ALUOUT]<=B, we_mem=1) -> FETCH.
- REQ-016 SHALL sequence R-type as EXECR -> ALUWB, and I-type ALU as EXECI -> ALUWB; ALUWB writes rd with we_rf=1.
- REQ-017 SHALL sequence branches as BRANCH: compare A and B; if taken PC<=ALUOUT; then FETCH.
- REQ-018 SHALL execute JAL as: rd<=OLDPC+4, PC<=OLDPC+imm_J, we_rf=1, then FETCH.
- REQ-019 SHALL execute JALR as: rd<=OLDPC+4, PC<=(A+imm_I)&~1, we_rf=1, then FETCH.
- REQ-020 SHALL execute UPPER as: rd<=imm_U (LUI) or OLDPC+imm_U (AUIPC), we_rf=1, then FETCH.
- REQ-021 SHALL have these cycles per instruction: LW 5; SW, ALU-R, ALU-I 4; JAL, JALR, LUI, AUIPC 3; branch 3; NOP 2.
- REQ-022 SHALL hold we_rf high exactly one cycle per register-writing instruction and we_mem high exactly one cycle per store; both SHALL be low in FETCH and DECODE, so every completing write produces a distinct rising edge.
- REQ-023 SHALL keep x0 at zero: writes to it are discarded, although we_rf still pulses.
- REQ-024 SHALL use 32-bit wrap-around arithmetic, with shift amounts taken from the low 5 bits, SRA/SRAI sign-filling, SLT signed and SLTU unsigned.
- REQ-025 SHALL commit a write only when the state-transition edge occurs; the rising edge that moves MEMWRITE to FETCH performs the store.

Reset
- REQ-026 SHALL, while rst=1 (asynchronously), force: PC=RESET_PC, state=FETCH, IR/OLDPC/A/B/ALUOUT/DATA=0, x1..x31=0, we_rf=0, we_mem=0.
- REQ-027 SHALL NOT reset memory contents, so a preloaded program survives reset.
- REQ-028 SHALL abandon any instruction in progress when reset is asserted mid-instruction, with no partial register or memory write; after release, execution restarts at RESET_PC.

Structure
- REQ-029 SHALL place opcode constants, funct3/funct7 constants, ALU-op encodings and the state enum in a shared package rv_mc_pkg.
- REQ-030 SHALL implement memory as a sub-module rv_mc_mem, instantiated as MEM; the register file, ALU, immediate generator and FSM SHALL live in rv_mc.

Verification
- REQ-031 SHALL cover: program ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2 -> x3=12, 12 cycles, three we_rf rising edges.
- REQ-032 SHALL cover: SW x3,64(x0) then LW x4,64(x0) -> RAM[16]=12, x4=12, one we_mem edge, LW taking 5 cycles.
- REQ-033 SHALL cover: BEQ x1,x1,+8 skipping ADDI x5,x0,1 -> x5=0, branch taking 3 cycles, no write pulse.
- REQ-034 SHALL cover: JAL x1,+16 at PC 0x20 -> x1=0x24, next fetch at 0x30; and JALR x0,0(x1) -> PC=0x24.
- REQ-035 SHALL cover: ADDI x0,x0,9 -> x0 stays 0 and we_rf pulses; LUI x6,0xFFFFF then SRAI x7,x6,4 -> x7=0xFFFFF000 then 0xFFFFFF00.
- REQ-036 SHALL cover: rst asserted during MEMWRITE -> no memory change, and PC=0 immediately (asynchronously).

Source files
------------

// File: rtl/rv_mc_pkg.sv
// Shared RV32I encodings, ALU operation codes and FSM states for the multi-cycle core.
package rv_mc_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER
   } state_t;

   // alt is instruction bit 30; it selects SUB only for register-register ops
   function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
      alu_op_t op;
      case (f3)
         F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_mc_mem.sv
// Unified word memory: combinational read, synchronous write, word index wraps modulo size.
module rv_mc_mem #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic [31:0]   RAM [0:MEM_WORDS-1];
   logic [AW-1:0] idx;
   logic          unused_addr;

   assign idx         = addr[AW+1:2];
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
   assign rdata       = RAM[idx];

   always_ff @(posedge clk) begin
      if (we) RAM[idx] <= wdata;
   end

endmodule

// File: rtl/rv_mc.sv
// Multi-cycle RV32I core: FSM, register file, immediates and a single shared ALU.
module rv_mc
   import rv_mc_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input logic clk,
   input logic rst
);

   state_t      state, state_nxt;
   logic [31:0] pc, oldpc, ir, a, b, aluout, data;
   logic [31:0] rf [0:31];
   logic        we_rf, we_mem, taken;
   logic [31:0] mem_addr, mem_rdata, wd;
   logic [31:0] alu_a, alu_b, alu_y;
   alu_op_t     alu_op;

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign f3     = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign imm_i  = {{20{ir[31]}}, ir[31:20]};
   assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u  = {ir[31:12], 12'b0};
   assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   assign mem_addr = (state == FETCH) ? pc : aluout;

   rv_mc_mem #(.MEM_WORDS(MEM_WORDS)) MEM (
      .clk   (clk),
      .we    (we_mem),
      .addr  (mem_addr),
      .wdata (b),
      .rdata (mem_rdata)
   );

   // Operand steering for the one ALU; FETCH uses it for PC+4
   always_comb begin
      alu_a  = pc;
      alu_b  = 32'd4;
      alu_op = ALU_ADD;
      case (state)
         DECODE: begin alu_a = oldpc; alu_b = imm_b; end
         MEMADR: begin alu_a = a; alu_b = (opcode == OP_STORE) ? imm_s : imm_i; end
         EXECR:  begin alu_a = a; alu_b = b;     alu_op = alu_decode(f3, ir[30], 1'b1); end
         EXECI:  begin alu_a = a; alu_b = imm_i; alu_op = alu_decode(f3, ir[30], 1'b0); end
         JAL:    begin alu_a = oldpc; alu_b = imm_j; end
         JALR:   begin alu_a = a;     alu_b = imm_i; end
         UPPER:  begin alu_a = oldpc; alu_b = imm_u; end
         default: ;
      endcase
   end

   always_comb begin
      case (alu_op)
         ALU_ADD:  alu_y = alu_a + alu_b;
         ALU_SUB:  alu_y = alu_a - alu_b;
         ALU_SLL:  alu_y = alu_a << alu_b[4:0];
         ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
         ALU_XOR:  alu_y = alu_a ^ alu_b;
         ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
         ALU_SRA:  alu_y = 32'($signed(alu_a) >>> alu_b[4:0]);
         ALU_OR:   alu_y = alu_a | alu_b;
         default:  alu_y = alu_a & alu_b;
      endcase
   end

   always_comb begin
      case (f3)
         F3_BEQ:  taken = (a == b);
         F3_BNE:  taken = (a != b);
         F3_BLT:  taken = ($signed(a) <  $signed(b));
         F3_BGE:  taken = ($signed(a) >= $signed(b));
         F3_BLTU: taken = (a <  b);
         F3_BGEU: taken = (a >= b);
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      we_rf     = 1'b0;
      we_mem    = 1'b0;
      case (state)
         FETCH:  state_nxt = DECODE;
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_nxt = MEMADR;
               OP_REG:            state_nxt = EXECR;
               OP_IMM:            state_nxt = EXECI;
               OP_BRANCH:         state_nxt = BRANCH;
               OP_JAL:            state_nxt = JAL;
               OP_JALR:           state_nxt = JALR;
               OP_LUI, OP_AUIPC:  state_nxt = UPPER;
               default:           state_nxt = FETCH;
            endcase
         end
         MEMADR:   state_nxt = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
         MEMREAD:  state_nxt = MEMWB;
         MEMWRITE: begin we_mem = 1'b1; state_nxt = FETCH; end
         EXECR, EXECI: state_nxt = ALUWB;
         MEMWB, ALUWB, JAL, JALR, UPPER: begin we_rf = 1'b1; state_nxt = FETCH; end
         default:  state_nxt = FETCH;
      endcase
   end

   always_comb begin
      wd = aluout;
      case (state)
         MEMWB:     wd = data;
         JAL, JALR: wd = oldpc + 32'd4;
         UPPER:     wd = (opcode == OP_LUI) ? imm_u : alu_y;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= RESET_PC;
         oldpc  <= '0;
         ir     <= '0;
         a      <= '0;
         b      <= '0;
         aluout <= '0;
         data   <= '0;
      end else begin
         case (state)
            FETCH: begin
               ir    <= mem_rdata;
               oldpc <= pc;
               pc    <= alu_y;
            end
            DECODE: begin
               a      <= rf[rs1];
               b      <= rf[rs2];
               aluout <= alu_y;
            end
            MEMADR, EXECR, EXECI: aluout <= alu_y;
            MEMREAD: data <= mem_rdata;
            BRANCH:  if (taken) pc <= aluout;
            JAL:     pc <= alu_y;
            JALR:    pc <= alu_y & ~32'd1;
            default: ;
         endcase
      end
   end

   // rf[0] is cleared by reset and never written, so x0 always reads zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
      end else if (we_rf && rd != 5'd0) begin
         rf[rd] <= wd;
      end
   end

endmodule

// File: tb/tb_rv_mc.sv
// Instruction-level reference model bench for rv_mc: directed ISA checks plus random programs.
module tb_rv_mc;

   localparam int unsigned MW = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rv_mc #(.MEM_WORDS(MW), .RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst)
   );

   int tests = 0;
   int fails = 0;
   int rf_edges = 0;
   int mem_edges = 0;
   int last_n = 0;

   logic [31:0] mr [0:31];
   logic [31:0] mm [0:MW-1];
   logic [31:0] mpc;
   logic [31:0] prog [$];

   always @(posedge dut.we_rf)  rf_edges++;
   always @(posedge dut.we_mem) mem_edges++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      logic [11:0] i12 = imm[11:0];
      return {i12, rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction
   function automatic logic [31:0] e_s(int imm, int rs2, int rs1);
      logic [11:0] i12 = imm[11:0];
      return {i12[11:5], rs2[4:0], rs1[4:0], 3'b010, i12[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] e_b(int imm, int rs2, int rs1, int f3);
      logic [12:0] i = imm[12:0];
      return {i[12], i[10:5], rs2[4:0], rs1[4:0], f3[2:0], i[4:1], i[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] e_u(int imm20, int rd, logic [6:0] op);
      return {imm20[19:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] e_j(int imm, int rd);
      logic [20:0] i = imm[20:0];
      return {i[20], i[10:1], i[11], i[19:12], rd[4:0], 7'b1101111};
   endfunction

   function automatic logic [31:0] alu_m(logic [2:0] f3, bit alt, logic [31:0] x, logic [31:0] y);
      int sh = int'(y[4:0]);
      case (f3)
         3'd0: return alt ? x - y : x + y;
         3'd1: return x << sh;
         3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         3'd3: return (x < y) ? 32'd1 : 32'd0;
         3'd4: return x ^ y;
         3'd5: return alt ? 32'($signed(x) >>> sh) : x >> sh;
         3'd6: return x | y;
         default: return x & y;
      endcase
   endfunction

   function automatic bit br_m(logic [2:0] f3, logic [31:0] x, logic [31:0] y);
      case (f3)
         3'd0: return x == y;
         3'd1: return x != y;
         3'd4: return $signed(x) < $signed(y);
         3'd5: return $signed(x) >= $signed(y);
         3'd6: return x < y;
         3'd7: return x >= y;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void wreg(logic [4:0] rd, logic [31:0] v);
      if (rd != 5'd0) mr[rd] = v;
   endfunction

   // Executes one instruction architecturally; reports its cycle count and write activity
   task automatic model_step(output int n, output bit wrf, output bit wmem, output int widx);
      logic [31:0] ins, x, y, ii, is, ib, iu, ij, nxt, ea;
      logic [4:0]  rd;
      logic [2:0]  f3;
      ins = mm[(mpc >> 2) % MW];
      rd  = ins[11:7];
      f3  = ins[14:12];
      x   = mr[ins[19:15]];
      y   = mr[ins[24:20]];
      ii  = 32'($signed(ins) >>> 20);
      is  = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
      ib  = (32'($signed(ins) >>> 31) << 12) | (32'(ins[7]) << 11)
          | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      iu  = ins & 32'hFFFF_F000;
      ij  = (32'($signed(ins) >>> 31) << 20) | (32'(ins[19:12]) << 12)
          | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      nxt = mpc + 4;
      n = 2; wrf = 0; wmem = 0; widx = -1;
      case (ins[6:0])
         7'h37: begin n = 3; wrf = 1; wreg(rd, iu); end
         7'h17: begin n = 3; wrf = 1; wreg(rd, mpc + iu); end
         7'h6F: begin n = 3; wrf = 1; wreg(rd, mpc + 4); nxt = mpc + ij; end
         7'h67: begin n = 3; wrf = 1; nxt = (x + ii) & ~32'd1; wreg(rd, mpc + 4); end
         7'h63: begin n = 3; if (br_m(f3, x, y)) nxt = mpc + ib; end
         7'h03: begin n = 5; wrf = 1; ea = x + ii; wreg(rd, mm[(ea >> 2) % MW]); end
         7'h23: begin n = 4; wmem = 1; ea = x + is; widx = int'((ea >> 2) % MW); mm[widx] = y; end
         7'h13: begin n = 4; wrf = 1; wreg(rd, alu_m(f3, f3 == 3'd5 && ins[30], x, ii)); end
         7'h33: begin n = 4; wrf = 1; wreg(rd, alu_m(f3, ins[30], x, y)); end
         default: ;
      endcase
      mpc = nxt;
   endtask

   task automatic check_regs(input string name);
      int bad = -1;
      for (int i = 0; i < 32; i++)
         if (bad < 0 && dut.rf[i] !== mr[i]) bad = i;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s: x%0d got %h expected %h", name, bad, dut.rf[bad], mr[bad]);
      end
   endtask

   // Entered just after an active edge with the DUT at an instruction boundary
   task automatic run_instr();
      int n, widx;
      bit wrf, wmem;
      model_step(n, wrf, wmem, widx);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         check("we_rf", {31'b0, dut.we_rf}, {31'b0, wrf && c == n - 1});
         check("we_mem", {31'b0, dut.we_mem}, {31'b0, wmem && c == n - 1});
         @(posedge clk);
      end
      #1;
      check("pc", dut.pc, mpc);
      check_regs("regs");
      if (widx >= 0) check("mem", dut.MEM.RAM[widx], mm[widx]);
      last_n = n;
   endtask

   task automatic reset_model();
      for (int i = 0; i < 32; i++) mr[i] = '0;
      mpc = '0;
   endtask

   task automatic load_and_reset(input bit rand_data);
      @(negedge clk);
      rst = 1'b1;
      #1;
      reset_model();
      check("rst_pc", dut.pc, 32'h0);
      check("rst_we", {30'b0, dut.we_rf, dut.we_mem}, 32'h0);
      check_regs("rst_regs");
      for (int i = 0; i < int'(MW); i++) begin
         mm[i] = (rand_data && i >= 384 && i < 512) ? $urandom : 32'h0;
         if (i < prog.size()) mm[i] = prog[i];
         dut.MEM.RAM[i] = mm[i];
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic gen_random_prog();
      int k, f3, rd, r1, r2, imm, alt;
      prog.delete();
      for (int p = 0; p < 40; p++) begin
         k  = $urandom_range(0, 9);
         f3 = $urandom_range(0, 7);
         rd = $urandom_range(0, 7);
         r1 = $urandom_range(0, 7);
         r2 = $urandom_range(0, 7);
         alt = $urandom_range(0, 1);
         case (k)
            0: prog.push_back(e_r(((f3 == 0 || f3 == 5) && alt == 1) ? 32 : 0, r2, r1, f3, rd));
            1: begin
               imm = $urandom_range(0, 4095);
               if (f3 == 1) imm = imm % 32;
               if (f3 == 5) imm = (imm % 32) + alt * 1024;
               prog.push_back(e_i(imm, r1, f3, rd, 7'h13));
            end
            2: prog.push_back(e_u($urandom, rd, 7'h37));
            3: prog.push_back(e_u($urandom, rd, 7'h17));
            4: prog.push_back(e_i('h600 + 4 * $urandom_range(0, 127), 0, 2, rd, 7'h03));
            5: prog.push_back(e_s('h600 + 4 * $urandom_range(0, 127), r2, 0));
            6: prog.push_back(e_b(8, r2, r1, (f3 == 2 || f3 == 3) ? 0 : f3));
            7: prog.push_back(e_j(8, rd));
            8: prog.push_back(e_i(4 * p + 8, 0, 0, rd, 7'h67));
            default: prog.push_back(alt == 1 ? 32'h0000_000F : 32'h0000_0073);
         endcase
      end
      prog.push_back(e_j(0, 0));
      prog.push_back(e_j(0, 0));
   endtask

   initial begin
      int e0, m0, tot;

      // Directed program covering arithmetic, memory, branch, jumps, x0 and upper-immediate cases
      prog = '{e_i(5, 0, 0, 1, 7'h13), e_i(7, 0, 0, 2, 7'h13), e_r(0, 2, 1, 0, 3),
               e_s(64, 3, 0), e_i(64, 0, 2, 4, 7'h03), e_b(8, 1, 1, 0),
               e_i(1, 0, 0, 5, 7'h13), e_i(9, 0, 0, 0, 7'h13), e_j(16, 1),
               e_u('hFFFFF, 6, 7'h37), e_i('h404, 6, 5, 7, 7'h13), e_j(0, 0),
               e_i(0, 1, 0, 0, 7'h67)};
      load_and_reset(1'b0);
      e0 = rf_edges; m0 = mem_edges; tot = 0;
      repeat (3) begin run_instr(); tot += last_n; end
      check("p1_cycles", tot, 12);
      check("p1_x3", dut.rf[3], 32'd12);
      check("p1_rf_edges", rf_edges - e0, 3);
      run_instr();
      run_instr();
      check("lw_cycles", last_n, 5);
      check("ram16", dut.MEM.RAM[16], 32'd12);
      check("x4", dut.rf[4], 32'd12);
      check("mem_edges", mem_edges - m0, 1);
      e0 = rf_edges;
      run_instr();
      check("beq_cycles", last_n, 3);
      check("beq_no_pulse", rf_edges - e0, 0);
      check("beq_pc", dut.pc, 32'h1C);
      run_instr();
      check("x0_pulse", rf_edges - e0, 1);
      check("x0_zero", dut.rf[0], 32'h0);
      check("x5_skipped", dut.rf[5], 32'h0);
      run_instr();
      check("jal_x1", dut.rf[1], 32'h24);
      check("jal_pc", dut.pc, 32'h30);
      run_instr();
      check("jalr_pc", dut.pc, 32'h24);
      run_instr();
      check("lui_x6", dut.rf[6], 32'hFFFF_F000);
      run_instr();
      check("srai_x7", dut.rf[7], 32'hFFFF_FF00);
      repeat (2) run_instr();

      // Reset during MEMWRITE must discard the store and clear PC at once
      prog = '{e_i(12, 0, 0, 3, 7'h13), e_s(64, 3, 0), e_j(0, 0)};
      load_and_reset(1'b0);
      mm[16] = 32'hDEAD_BEEF;
      dut.MEM.RAM[16] = 32'hDEAD_BEEF;
      run_instr();
      repeat (3) @(posedge clk);
      #1;
      check("in_memwrite", {31'b0, dut.we_mem}, 32'd1);
      rst = 1'b1;
      #1;
      check("async_pc", dut.pc, 32'h0);
      check("async_we_mem", {31'b0, dut.we_mem}, 32'd0);
      @(posedge clk);
      #1;
      check("ram_kept", dut.MEM.RAM[16], 32'hDEAD_BEEF);
      rst = 1'b0;
      reset_model();
      repeat (3) run_instr();
      check("restart_store", dut.MEM.RAM[16], 32'd12);

      // Random programs against the instruction-level model
      for (int t = 0; t < 4; t++) begin
         gen_random_prog();
         load_and_reset(1'b1);
         repeat (60) run_instr();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
